// File: rtl/td4x_cpu.sv
// td4x_cpu: a TD4-style 4-bit-opcode CPU with a writable program store.
// It has two data registers (A, B), an output register, a carry flag and a
// halt flag. Instructions execute at a divided tick rate while run=1, or one
// per step pulse while run=0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (program store is kept)
//   run        1 = free-run at tick rate, 0 = paused (load / single-step)
//   step       executes one instruction on this edge while run=0
//   prog_we    program-store write enable (honoured only while run=0)
//   prog_addr  program-store write address
//   prog_data  instruction word: [DW+3:DW] opcode, [DW-1:0] immediate
//   in_port    input port read by IN A / IN B
//   out_port   output register
//   pc         program counter
//   carry      carry flag
//   halted     set by HLT, cleared only by rst
module td4x_cpu #(
    parameter int DW  = 4,
    parameter int AW  = 4,
    parameter int DIV = 500000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          step,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW+3:0] prog_data,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic [AW-1:0] pc,
    output logic          carry,
    output logic          halted
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_A  = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_B  = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_IM = 4'b1011,
        OP_HLT    = 4'b1101,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_t;

    logic [DW+3:0] store [2**AW];
    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;
    logic [CW-1:0] div_cnt;

    logic          tick;
    logic          exec;
    logic [DW+3:0] instr;
    logic [3:0]    opcode;
    logic [DW-1:0] im;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_next;
    logic [DW:0]   sum_a;
    logic [DW:0]   sum_b;

    assign tick    = (div_cnt == CW'(DIV - 1));
    assign exec    = ~halted & (run ? tick : step);
    // Asynchronous read: the instruction is the word held before this edge,
    // so a same-edge write to store[pc] cannot affect it.
    assign instr   = store[pc];
    assign opcode  = instr[DW+3:DW];
    assign im      = instr[DW-1:0];
    assign pc_next = pc + AW'(1);
    assign sum_a   = {1'b0, reg_a} + {1'b0, im};
    assign sum_b   = {1'b0, reg_b} + {1'b0, im};

    // Jump target: low AW bits of the immediate, or the immediate
    // zero-extended when the address is wider than the data path.
    if (AW <= DW) begin : g_tgt_slice
        assign target = im[AW-1:0];
    end else begin : g_tgt_ext
        assign target = {{(AW - DW){1'b0}}, im};
    end

    // NOTE: the program store has no reset branch so it maps onto plain RAM;
    // its contents survive rst by design. rst still blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && !run) begin
            store[prog_addr] <= prog_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; a default
    // (carry cleared, pc incremented) is assigned first and the opcode case
    // overrides it -- the last non-blocking assignment in the block wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= '0;
            carry    <= 1'b0;
            halted   <= 1'b0;
            div_cnt  <= '0;
        end else begin
            // Divider only counts while free-running; pausing or halting
            // parks it at 0 so the next tick is a full DIV clocks away.
            if (run && !halted) begin
                div_cnt <= tick ? '0 : div_cnt + CW'(1);
            end else begin
                div_cnt <= '0;
            end

            if (exec) begin
                carry <= 1'b0;
                pc    <= pc_next;
                case (opcode)
                    OP_ADD_A: begin
                        reg_a <= sum_a[DW-1:0];
                        carry <= sum_a[DW];
                    end
                    OP_ADD_B: begin
                        reg_b <= sum_b[DW-1:0];
                        carry <= sum_b[DW];
                    end
                    OP_MOV_A:  reg_a    <= im;
                    OP_MOV_B:  reg_b    <= im;
                    OP_MOV_AB: reg_a    <= reg_b;
                    OP_MOV_BA: reg_b    <= reg_a;
                    OP_IN_A:   reg_a    <= in_port;
                    OP_IN_B:   reg_b    <= in_port;
                    OP_OUT_B:  out_port <= reg_b;
                    OP_OUT_IM: out_port <= im;
                    OP_JMP:    pc       <= target;
                    // carry here is the flag held before this edge.
                    OP_JNC: begin
                        if (!carry) pc <= target;
                    end
                    OP_HLT: begin
                        halted <= 1'b1;
                        pc     <= pc;
                    end
                    default: ;  // unlisted opcodes act as NOP
                endcase
            end
        end
    end

endmodule

// File: tb/tb_td4x_cpu.sv
// Self-checking bench for td4x_cpu. Three instances cover the parameter sets
// needed: u_a (DW=4, AW=4, DIV=1), u_b (DW=4, AW=4, DIV=3), u_c (DW=8, AW=4,
// DIV=1). Expected values are queued when stimulus is driven and popped in
// order when the corresponding output is sampled (on the falling edge).
module tb_td4x_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- instance A: DW=4, AW=4, DIV=1
    logic       rst_a, run_a, step_a, we_a;
    logic [3:0] addr_a, in_a, out_a, pc_a;
    logic [7:0] data_a;
    logic       carry_a, halted_a;

    // ---- instance B: DW=4, AW=4, DIV=3
    logic       rst_b, run_b, step_b, we_b;
    logic [3:0] addr_b, in_b, out_b, pc_b;
    logic [7:0] data_b;
    logic       carry_b, halted_b;

    // ---- instance C: DW=8, AW=4, DIV=1
    logic        rst_c, run_c, step_c, we_c;
    logic [3:0]  addr_c, pc_c;
    logic [7:0]  in_c, out_c;
    logic [11:0] data_c;
    logic        carry_c, halted_c;

    td4x_cpu #(.DW(4), .AW(4), .DIV(1)) u_a (
        .clk(clk), .rst(rst_a), .run(run_a), .step(step_a), .prog_we(we_a),
        .prog_addr(addr_a), .prog_data(data_a), .in_port(in_a),
        .out_port(out_a), .pc(pc_a), .carry(carry_a), .halted(halted_a)
    );

    td4x_cpu #(.DW(4), .AW(4), .DIV(3)) u_b (
        .clk(clk), .rst(rst_b), .run(run_b), .step(step_b), .prog_we(we_b),
        .prog_addr(addr_b), .prog_data(data_b), .in_port(in_b),
        .out_port(out_b), .pc(pc_b), .carry(carry_b), .halted(halted_b)
    );

    td4x_cpu #(.DW(8), .AW(4), .DIV(1)) u_c (
        .clk(clk), .rst(rst_c), .run(run_c), .step(step_c), .prog_we(we_c),
        .prog_addr(addr_c), .prog_data(data_c), .in_port(in_c),
        .out_port(out_c), .pc(pc_c), .carry(carry_c), .halted(halted_c)
    );

    // ---- scoreboard
    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_a(input logic [3:0] addr, input logic [7:0] data);
        we_a = 1'b1; addr_a = addr; data_a = data;
        cyc(1);
        we_a = 1'b0;
    endtask

    task automatic load_b(input logic [3:0] addr, input logic [7:0] data);
        we_b = 1'b1; addr_b = addr; data_b = data;
        cyc(1);
        we_b = 1'b0;
    endtask

    task automatic load_c(input logic [3:0] addr, input logic [11:0] data);
        we_c = 1'b1; addr_c = addr; data_c = data;
        cyc(1);
        we_c = 1'b0;
    endtask

    task automatic step_a_n(input int n);
        step_a = 1'b1;
        cyc(n);
        step_a = 1'b0;
    endtask

    task automatic step_c_1();
        step_c = 1'b1;
        cyc(1);
        step_c = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; run_a = 1'b0; step_a = 1'b0; we_a = 1'b0;
        addr_a = '0; data_a = '0; in_a = '0;
        rst_b = 1'b1; run_b = 1'b0; step_b = 1'b0; we_b = 1'b0;
        addr_b = '0; data_b = '0; in_b = '0;
        rst_c = 1'b1; run_c = 1'b0; step_c = 1'b0; we_c = 1'b0;
        addr_c = '0; data_c = '0; in_c = '0;
        cyc(2);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // ---------------- reset state
        expect_val("rst_out", 0);    check(out_a);
        expect_val("rst_pc", 0);     check(pc_a);
        expect_val("rst_carry", 0);  check(carry_a);
        expect_val("rst_halted", 0); check(halted_a);

        // ---------------- demo program, DIV=1 free run
        load_a(4'd0, 8'b0011_0001);  // MOV A,1
        load_a(4'd1, 8'b0000_1111);  // ADD A,F -> carry
        load_a(4'd2, 8'b1110_0000);  // JNC 0 (falls through)
        load_a(4'd3, 8'b1011_1010);  // OUT 1010
        load_a(4'd4, 8'b1101_0000);  // HLT
        expect_val("load_idle_pc", 0); check(pc_a);
        run_a = 1'b1;
        cyc(2);
        expect_val("add_carry", 1);  check(carry_a);
        expect_val("add_pc", 2);     check(pc_a);
        cyc(1);
        expect_val("jnc_fall_pc", 3);    check(pc_a);
        expect_val("jnc_fall_carry", 0); check(carry_a);
        cyc(2);
        expect_val("demo_out", 4'b1010); check(out_a);
        expect_val("demo_carry", 0);     check(carry_a);
        expect_val("demo_halted", 1);    check(halted_a);
        expect_val("demo_pc", 4);        check(pc_a);
        cyc(3);
        expect_val("hold_pc", 4);        check(pc_a);
        expect_val("hold_out", 4'b1010); check(out_a);

        // write attempt while run=1 must be ignored (store[4] stays HLT)
        load_a(4'd4, 8'b1011_0101);

        // ---------------- reset from arbitrary (halted) state
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0; run_a = 1'b0;
        expect_val("rst2_out", 0);    check(out_a);
        expect_val("rst2_pc", 0);     check(pc_a);
        expect_val("rst2_carry", 0);  check(carry_a);
        expect_val("rst2_halted", 0); check(halted_a);

        // ---------------- single-step IN / MOV / OUT
        in_a = 4'b0110;
        load_a(4'd0, 8'b0010_0000);  // IN A
        load_a(4'd1, 8'b0100_0000);  // MOV B,A
        load_a(4'd2, 8'b1001_0000);  // OUT B
        cyc(2);
        expect_val("paused_pc", 0); check(pc_a);
        step_a_n(1);
        expect_val("step1_pc", 1);  check(pc_a);
        step_a_n(2);
        expect_val("step_out", 4'b0110); check(out_a);
        expect_val("step_pc", 3);        check(pc_a);
        step_a_n(1);
        expect_val("old_out_im", 4'b1010); check(out_a);
        step_a_n(1);
        expect_val("store_kept_halt", 1);  check(halted_a);
        expect_val("store_kept_out", 4'b1010); check(out_a);
        expect_val("store_kept_pc", 4);    check(pc_a);

        // ---------------- JNC jump and pc wrap
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0;
        for (int i = 0; i < 16; i++) load_a(4'(i), 8'h00);  // ADD A,0
        load_a(4'd0, 8'b0011_1111);  // MOV A,F
        load_a(4'd1, 8'b0000_0001);  // ADD A,1 -> carry=1
        load_a(4'd2, 8'b1110_0000);  // JNC 0 (falls through)
        load_a(4'd4, 8'b1110_1000);  // JNC 8 (taken)
        step_a_n(3);
        expect_val("jnc_c1_pc", 3);    check(pc_a);
        step_a_n(2);
        expect_val("jnc_c0_pc", 8);    check(pc_a);
        step_a_n(7);
        expect_val("pre_wrap_pc", 15); check(pc_a);
        step_a_n(1);
        expect_val("wrap_pc", 0);      check(pc_a);
        expect_val("wrap_halted", 0);  check(halted_a);

        // ---------------- DIV=3 timing
        for (int i = 0; i < 16; i++) load_b(4'(i), 8'b0000_0001);  // ADD A,1
        run_b = 1'b1;
        cyc(2);
        expect_val("div_2clk_pc", 0); check(pc_b);
        cyc(1);
        expect_val("div_3clk_pc", 1); check(pc_b);
        cyc(2);
        expect_val("div_5clk_pc", 1); check(pc_b);
        cyc(1);
        expect_val("div_6clk_pc", 2); check(pc_b);
        cyc(1);                      // divider mid-count
        run_b = 1'b0;
        cyc(2);
        expect_val("pause_pc", 2);    check(pc_b);
        run_b = 1'b1; step_b = 1'b1; // step must be ignored while running
        cyc(2);
        step_b = 1'b0;
        expect_val("restart_2clk_pc", 2); check(pc_b);
        cyc(1);
        expect_val("restart_3clk_pc", 3); check(pc_b);

        // ---------------- DW=8 add carry
        load_c(4'd0,  12'hB77);  // OUT 77
        load_c(4'd1,  12'h3FF);  // MOV A,FF
        load_c(4'd2,  12'h001);  // ADD A,01
        load_c(4'd3,  12'h35A);  // MOV A,5A
        load_c(4'd4,  12'h3FF);  // MOV A,FF
        load_c(4'd5,  12'h001);  // ADD A,01
        load_c(4'd6,  12'h400);  // MOV B,A
        load_c(4'd7,  12'h900);  // OUT B
        load_c(4'd8,  12'h5FF);  // ADD B,FF
        load_c(4'd9,  12'h900);  // OUT B
        load_c(4'd10, 12'h501);  // ADD B,01
        load_c(4'd11, 12'hBC3);  // OUT C3
        step_c_1();
        expect_val("c_out77", 8'h77); check(out_c);
        step_c_1();
        step_c_1();
        expect_val("c8_add_carry", 1); check(carry_c);
        step_c_1();
        expect_val("c8_mov_carry", 0); check(carry_c);
        step_c_1();
        step_c_1();
        expect_val("c8_add2_carry", 1); check(carry_c);
        step_c_1();
        expect_val("c8_movba_carry", 0); check(carry_c);
        step_c_1();
        expect_val("c8_a_zero", 8'h00); check(out_c);
        step_c_1();
        expect_val("c8_addb_carry", 0); check(carry_c);
        step_c_1();
        expect_val("c8_b_ff", 8'hFF);   check(out_c);
        step_c_1();
        expect_val("c8_addb_wrap_carry", 1); check(carry_c);
        step_c_1();
        expect_val("c8_out_c3", 8'hC3); check(out_c);
        expect_val("c8_pc", 12);        check(pc_c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
